vga_plot_arbiter: RTL and testbench

- Single owner of the vga_adapter pixel-write port (x, y, colour, plot) in the 160x120 snake display.
- Shares the port between two pixel requesters (player 1 and player 2 renderers) using round-robin arbitration.
- Contains a rectangle-fill sequencer for screen clears, background patches and food/erase blocks.
- The fill sequencer locks out both requesters until it completes.

---
 rtl/vga_plot_arbiter_if.sv | 57 +++++
 rtl/vga_plot_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_plot_arbiter_if.sv
// Pixel-port bundle for vga_plot_arbiter: fill command, two requesters and the
// vga_adapter write port. The arbiter takes the slave side.
interface vga_plot_arbiter_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7,
  parameter int unsigned CW = 3
);
  // Rectangle fill command
  logic          fill_start;
  logic [XW-1:0] fill_x0;
  logic [YW-1:0] fill_y0;
  logic [XW-1:0] fill_w;
  logic [YW-1:0] fill_h;
  logic [CW-1:0] fill_colour;
  logic          fill_busy;
  logic          fill_done;

  // Requester 0 (player 1)
  logic          req0_valid;
  logic [XW-1:0] req0_x;
  logic [YW-1:0] req0_y;
  logic [CW-1:0] req0_colour;
  logic          req0_ready;

  // Requester 1 (player 2)
  logic          req1_valid;
  logic [XW-1:0] req1_x;
  logic [YW-1:0] req1_y;
  logic [CW-1:0] req1_colour;
  logic          req1_ready;

  // vga_adapter write port
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;

  modport master (
    output fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_colour,
    input  fill_busy, fill_done,
    output req0_valid, req0_x, req0_y, req0_colour,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_colour,
    input  req1_ready,
    input  x, y, colour, plot
  );

  modport slave (
    input  fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_colour,
    output fill_busy, fill_done,
    input  req0_valid, req0_x, req0_y, req0_colour,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_colour,
    output req1_ready,
    output x, y, colour, plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Single owner of the vga_adapter pixel port. Round-robin between two pixel
// requesters, plus a rectangle-fill sequencer that locks both out while it runs.
// All port outputs except the ready lines are registered (one cycle latency).
module vga_plot_arbiter #(
  parameter int unsigned H_RES = 160,
  parameter int unsigned V_RES = 120,
  parameter int unsigned XW    = 8,
  parameter int unsigned YW    = 7,
  parameter int unsigned CW    = 3
) (
  input logic                CLOCK_50,
  input logic                resetn,
  vga_plot_arbiter_if.slave  bus
);

  localparam logic [XW:0] HResL = H_RES[XW:0];
  localparam logic [YW:0] VResL = V_RES[YW:0];

  typedef enum logic [0:0] {StArb, StFill} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] colour_q, colour_d;
  logic          plot_q, plot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Captured fill command and offset of the pixel currently presented
  logic [XW-1:0] fx0_q, fx0_d, fw_q, fw_d, ox_q, ox_d;
  logic [YW-1:0] fy0_q, fy0_d, fh_q, fh_d, oy_q, oy_d;
  logic [CW-1:0] fcol_q, fcol_d;

  logic          ready0, ready1, fill_empty;
  logic [XW:0]   px;
  logic [YW:0]   py;

  // Extra top bit on the coordinates keeps x0+w / y0+h from wrapping back on-screen
  function automatic logic on_screen(input logic [XW:0] cx, input logic [YW:0] cy);
    return (cx < HResL) && (cy < VResL);
  endfunction

  // Round-robin grant; a fill start in the same cycle beats both requesters
  always_comb begin
    ready0 = (state_q == StArb) && !bus.fill_start && bus.req0_valid &&
             (!bus.req1_valid || last_grant_q);
    ready1 = (state_q == StArb) && !bus.fill_start && bus.req1_valid &&
             (!bus.req0_valid || !last_grant_q);
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.colour      = colour_q;
  assign bus.plot        = plot_q;
  assign bus.fill_busy   = busy_q;
  assign bus.fill_done   = done_q;

  // Next-state: arbitration, fill capture and row-major fill stepping
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    fx0_d        = fx0_q;
    fy0_d        = fy0_q;
    fw_d         = fw_q;
    fh_d         = fh_q;
    fcol_d       = fcol_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    px           = '0;
    py           = '0;
    fill_empty   = (bus.fill_w == '0) || (bus.fill_h == '0);

    unique case (state_q)
      StArb: begin
        if (bus.fill_start) begin
          // First fill pixel is presented in the first FILL cycle
          fx0_d    = bus.fill_x0;
          fy0_d    = bus.fill_y0;
          fw_d     = bus.fill_w;
          fh_d     = bus.fill_h;
          fcol_d   = bus.fill_colour;
          ox_d     = '0;
          oy_d     = '0;
          x_d      = bus.fill_x0;
          y_d      = bus.fill_y0;
          colour_d = bus.fill_colour;
          plot_d   = !fill_empty && on_screen({1'b0, bus.fill_x0}, {1'b0, bus.fill_y0});
          busy_d   = 1'b1;
          done_d   = fill_empty || ((bus.fill_w == XW'(1)) && (bus.fill_h == YW'(1)));
          state_d  = StFill;
        end else if (ready0) begin
          x_d          = bus.req0_x;
          y_d          = bus.req0_y;
          colour_d     = bus.req0_colour;
          plot_d       = on_screen({1'b0, bus.req0_x}, {1'b0, bus.req0_y});
          last_grant_d = 1'b0;
        end else if (ready1) begin
          x_d          = bus.req1_x;
          y_d          = bus.req1_y;
          colour_d     = bus.req1_colour;
          plot_d       = on_screen({1'b0, bus.req1_x}, {1'b0, bus.req1_y});
          last_grant_d = 1'b1;
        end
      end
      StFill: begin
        if (done_q) begin
          state_d = StArb;
        end else begin
          if (ox_q == fw_q - XW'(1)) begin
            ox_d = '0;
            oy_d = oy_q + YW'(1);
          end else begin
            ox_d = ox_q + XW'(1);
          end
          px       = {1'b0, fx0_q} + {1'b0, ox_d};
          py       = {1'b0, fy0_q} + {1'b0, oy_d};
          x_d      = px[XW-1:0];
          y_d      = py[YW-1:0];
          colour_d = fcol_q;
          plot_d   = on_screen(px, py);
          busy_d   = 1'b1;
          done_d   = (ox_d == fw_q - XW'(1)) && (oy_d == fh_q - YW'(1));
        end
      end
      default: state_d = StArb;
    endcase
  end

  // State and registered outputs; reset abandons any fill without a done pulse
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q      <= StArb;
      last_grant_q <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fx0_q        <= '0;
      fy0_q        <= '0;
      fw_q         <= '0;
      fh_q         <= '0;
      fcol_q       <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fx0_q        <= fx0_d;
      fy0_q        <= fy0_d;
      fw_q         <= fw_d;
      fh_q         <= fh_d;
      fcol_q       <= fcol_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomized bench for vga_plot_arbiter against a pixel-list reference model.
module tb_vga_plot_arbiter;

  logic CLOCK_50 = 1'b0;
  logic resetn;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_plot_arbiter_if #(.XW(8), .YW(7), .CW(3)) bus ();

  vga_plot_arbiter #(
    .H_RES(160), .V_RES(120), .XW(8), .YW(7), .CW(3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  typedef struct {
    int x;
    int y;
    int c;
    bit on;
  } pix_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: ownership, last grant, remaining fill pixels, expected outputs
  bit   m_known = 0;
  bit   m_fill  = 0;
  bit   m_lg    = 1;
  pix_t m_q[$];
  bit   e_plot, e_busy, e_done, e_xy;
  int   e_x, e_y, e_c;
  bit   acc0, acc1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit on_scr(input int px, input int py);
    return (px < 160) && (py < 120);
  endfunction

  task automatic present(input pix_t p, input bit busy, input bit done);
    e_plot = p.on;
    e_xy   = p.on;
    e_x    = p.x;
    e_y    = p.y;
    e_c    = p.c;
    e_busy = busy;
    e_done = done;
  endtask

  // Expand the fill into its full row-major pixel list, then present the first
  task automatic load_fill(input int x0, input int y0, input int w, input int h, input int c);
    pix_t p;
    m_q.delete();
    if (w == 0 || h == 0) begin
      p = '{x: 0, y: 0, c: 0, on: 1'b0};
      m_q.push_back(p);
    end else begin
      for (int j = 0; j < h; j++)
        for (int i = 0; i < w; i++) begin
          p = '{x: x0 + i, y: y0 + j, c: c, on: on_scr(x0 + i, y0 + j)};
          m_q.push_back(p);
        end
    end
    p = m_q.pop_front();
    present(p, 1'b1, m_q.size() == 0);
    m_fill = 1'b1;
  endtask

  // One clock cycle: check current outputs/readies, advance the model, cross the edge
  task automatic step();
    bit   fs, v0, v1, r0e, r1e;
    pix_t p;
    #3;
    fs  = bus.fill_start;
    v0  = bus.req0_valid;
    v1  = bus.req1_valid;
    r0e = !m_fill && !fs && v0 && (!v1 || m_lg);
    r1e = !m_fill && !fs && v1 && (!v0 || !m_lg);
    if (m_known) begin
      check_eq("req0_ready", int'(bus.req0_ready), int'(r0e));
      check_eq("req1_ready", int'(bus.req1_ready), int'(r1e));
      check_eq("ready_onehot", int'(bus.req0_ready & bus.req1_ready), 0);
      check_eq("plot", int'(bus.plot), int'(e_plot));
      check_eq("fill_busy", int'(bus.fill_busy), int'(e_busy));
      check_eq("fill_done", int'(bus.fill_done), int'(e_done));
      if (e_xy) begin
        check_eq("x", int'(bus.x), e_x);
        check_eq("y", int'(bus.y), e_y);
        check_eq("colour", int'(bus.colour), e_c);
      end
    end
    acc0 = v0 && r0e;
    acc1 = v1 && r1e;
    if (!resetn) begin
      m_known = 1'b1;
      m_fill  = 1'b0;
      m_lg    = 1'b1;
      m_q.delete();
      p = '{x: 0, y: 0, c: 0, on: 1'b0};
      present(p, 1'b0, 1'b0);
      e_xy = 1'b1;
    end else if (!m_fill) begin
      if (fs) begin
        load_fill(int'(bus.fill_x0), int'(bus.fill_y0), int'(bus.fill_w),
                  int'(bus.fill_h), int'(bus.fill_colour));
      end else if (acc0 || acc1) begin
        if (acc0) p = '{x: int'(bus.req0_x), y: int'(bus.req0_y), c: int'(bus.req0_colour),
                        on: on_scr(int'(bus.req0_x), int'(bus.req0_y))};
        else      p = '{x: int'(bus.req1_x), y: int'(bus.req1_y), c: int'(bus.req1_colour),
                        on: on_scr(int'(bus.req1_x), int'(bus.req1_y))};
        present(p, 1'b0, 1'b0);
        e_xy = 1'b1;
        if (!p.on) e_xy = 1'b0;
        m_lg = acc1;
      end else begin
        // Nothing accepted: outputs hold, plot drops
        e_plot = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
      end
    end else if (m_q.size() == 0) begin
      m_fill = 1'b0;
      e_plot = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
    end else begin
      p = m_q.pop_front();
      present(p, 1'b1, m_q.size() == 0);
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic new_req(input int k);
    logic [7:0] rx;
    logic [6:0] ry;
    logic [2:0] rc;
    rx = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
    ry = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 119));
    rc = 3'($urandom_range(0, 7));
    if (k == 0) begin
      bus.req0_valid = 1'b1; bus.req0_x = rx; bus.req0_y = ry; bus.req0_colour = rc;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_x = rx; bus.req1_y = ry; bus.req1_colour = rc;
    end
  endtask

  // Requesters: after an accept either offer a fresh pixel or go idle
  task automatic post_accept(input bit keep0, input bit keep1);
    if (acc0) begin
      if (keep0) new_req(0);
      else bus.req0_valid = 1'b0;
    end
    if (acc1) begin
      if (keep1) new_req(1);
      else bus.req1_valid = 1'b0;
    end
  endtask

  task automatic set_fill(input int x0, input int y0, input int w, input int h, input int c);
    bus.fill_x0     = 8'(x0);
    bus.fill_y0     = 7'(y0);
    bus.fill_w      = 8'(w);
    bus.fill_h      = 7'(h);
    bus.fill_colour = 3'(c);
  endtask

  task automatic do_fill(input int x0, input int y0, input int w, input int h, input int c);
    int n;
    n = (w * h == 0) ? 1 : w * h;
    set_fill(x0, y0, w, h, c);
    bus.fill_start = 1'b1;
    step();
    post_accept(1'b0, 1'b0);
    bus.fill_start = 1'b0;
    repeat (n + 2) begin
      step();
      post_accept(1'b0, 1'b0);
    end
  endtask

  initial begin
    resetn         = 1'b0;
    bus.fill_start = 1'b0;
    set_fill(0, 0, 0, 0, 0);
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0; bus.req0_colour = '0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0; bus.req1_colour = '0;
    @(posedge CLOCK_50);
    #1;
    step();
    step();
    resetn = 1'b1;

    // Both requesters held valid: grants alternate starting with req0
    new_req(0);
    new_req(1);
    repeat (8) begin
      step();
      post_accept(1'b1, 1'b1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();

    // On-screen fill, then a fill clipped at the bottom-right corner
    do_fill(10, 20, 3, 2, 4);
    do_fill(158, 119, 4, 2, 5);

    // fill_start collides with a request that is held through the fill
    new_req(0);
    do_fill(5, 5, 2, 2, 1);

    // Degenerate fill
    do_fill(0, 0, 0, 5, 2);

    // Reset during the third pixel of a 10x10 fill
    set_fill(30, 40, 10, 10, 6);
    bus.fill_start = 1'b1;
    step();
    bus.fill_start = 1'b0;
    step();
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    new_req(0);
    step();
    post_accept(1'b0, 1'b0);
    step();

    // Random traffic with fills, ignored fill_starts during fills and stray resets
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit keep0, keep1;
      set_fill($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 6),
               $urandom_range(0, 5), $urandom_range(0, 7));
      bus.fill_start = m_fill ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 19) == 0);
      resetn = ($urandom_range(0, 199) != 0);
      if (!bus.req0_valid && $urandom_range(0, 9) < 4) new_req(0);
      if (!bus.req1_valid && $urandom_range(0, 9) < 4) new_req(1);
      step();
      keep0 = $urandom_range(0, 1) == 1;
      keep1 = $urandom_range(0, 1) == 1;
      post_accept(keep0, keep1);
    end
    resetn = 1'b1;
    bus.fill_start = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
